// File: rtl/fetch_align_queue.sv
// rtl/fetch_align_queue.sv - prefetch/alignment parcel queue delivering one instruction per cycle (optional RVC via FETCH_ALIGN_RVC_EN)
module fetch_align_queue #(
    parameter int          DEPTH    = 8,
    parameter logic [31:0] RESET_PC = 32'h0
) (
    input  logic                     clk,
    input  logic                     rst,
    output logic                     imem_req,
    output logic [31:0]              imem_addr,
    input  logic [31:0]              imem_rdata,
    input  logic                     redirect,
    input  logic [31:0]              redirect_pc,
    input  logic                     stall,
    output logic                     instr_valid,
    output logic [31:0]              instr_o,
    output logic                     instr_is_c,
    output logic [31:0]              instr_pc,
    output logic [31:0]              instr_pc_nxt,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam logic [CW-1:0] LIM_TWO = CW'(DEPTH - 2);
    localparam logic [CW-1:0] LIM_ONE = CW'(DEPTH - 1);

    logic [15:0]   buf_q [DEPTH];
    logic [AW-1:0] rd_ptr;
    logic [AW-1:0] wr_ptr;
    logic [CW-1:0] count_q;
    logic [31:0]   fetch_pc;
    logic [31:0]   head_pc;

    logic [15:0]   p0;
    logic [15:0]   p1;
    logic          head_is_c;
    logic          fetch_half;
    logic [31:0]   target_pc;
    logic          pop;
    logic [CW-1:0] push_n;
    logic [CW-1:0] pop_n;
    logic          unused_bits;

    assign p0 = buf_q[rd_ptr];
    assign p1 = buf_q[rd_ptr + AW'(1)];

`ifdef FETCH_ALIGN_RVC_EN
    // Head parcel is compressed unless its low two bits are 11; gated so an empty queue reports 32-bit.
    assign head_is_c  = (count_q != '0) && (p0[1:0] != 2'b11);
    assign target_pc  = {redirect_pc[31:1], 1'b0};
    assign fetch_half = fetch_pc[1];
`else
    assign head_is_c  = 1'b0;
    assign target_pc  = {redirect_pc[31:2], 2'b00};
    assign fetch_half = 1'b0;
`endif

    assign unused_bits = ^{redirect_pc[1:0], fetch_pc[1:0]};

    assign count        = count_q;
    assign instr_is_c   = head_is_c;
    assign instr_valid  = head_is_c ? (count_q >= CW'(1)) : (count_q >= CW'(2));
    assign instr_o      = !instr_valid ? 32'h0 :
                          head_is_c    ? {16'h0, p0} : {p1, p0};
    assign instr_pc     = head_pc;
    assign instr_pc_nxt = head_pc + (head_is_c ? 32'd2 : 32'd4);

    // A halfword-aligned fetch only adds one parcel, so it still fits with one slot left.
    assign imem_req  = !rst && !redirect &&
                       ((count_q <= LIM_TWO) || ((count_q == LIM_ONE) && fetch_half));
    assign imem_addr = {fetch_pc[31:2], 2'b00};

    assign pop    = instr_valid && !stall && !redirect;
    assign push_n = imem_req ? (fetch_half ? CW'(1) : CW'(2)) : '0;
    assign pop_n  = pop ? (head_is_c ? CW'(1) : CW'(2)) : '0;

    // Parcel storage: low half first, or only the high half for a mid-word fetch.
    always_ff @(posedge clk) begin
        if (imem_req) begin
            if (fetch_half) begin
                buf_q[wr_ptr] <= imem_rdata[31:16];
            end else begin
                buf_q[wr_ptr]          <= imem_rdata[15:0];
                buf_q[wr_ptr + AW'(1)] <= imem_rdata[31:16];
            end
        end
    end

    // Pointers, occupancy and PCs; redirect flushes and retargets ahead of pop/fetch.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_ptr   <= '0;
            wr_ptr   <= '0;
            count_q  <= '0;
            fetch_pc <= RESET_PC;
            head_pc  <= RESET_PC;
        end else if (redirect) begin
            rd_ptr   <= '0;
            wr_ptr   <= '0;
            count_q  <= '0;
            fetch_pc <= target_pc;
            head_pc  <= target_pc;
        end else begin
            if (imem_req) begin
                wr_ptr   <= wr_ptr + push_n[AW-1:0];
                fetch_pc <= {fetch_pc[31:2] + 30'd1, 2'b00};
            end
            if (pop) begin
                rd_ptr  <= rd_ptr + pop_n[AW-1:0];
                head_pc <= instr_pc_nxt;
            end
            count_q <= count_q + push_n - pop_n;
        end
    end

endmodule
